// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: assembles big-endian 32-bit fetches from a byte-wide
// single-port RAM and arbitrates that port with the boot loader's byte writes.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [31:0]       fetch_pc,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic              rsp_err,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  logic              pc_bad;

  assign pc_bad = (fetch_pc[1:0] != 2'b00) || ((fetch_pc >> ADDR_W) != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    instr_d     = instr_q;
    err_d       = err_q;
    fetch_ready = 1'b0;
    ld_ready    = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        ld_ready    = 1'b1;
        fetch_ready = !ld_valid && !flush;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end else if (fetch_valid && !flush) begin
          // Only the low address bits are kept: a good fetch has the rest zero.
          base_d  = fetch_pc[ADDR_W-1:0];
          cnt_d   = '0;
          instr_d = '0;
          err_d   = pc_bad;
          state_d = pc_bad ? S_RESP : S_FETCH;
        end
      end

      S_FETCH: begin
        if (cnt_q <= 3'd3) begin
          mem_en   = 1'b1;
          mem_addr = base_q + ADDR_W'(cnt_q);
        end
        if (!flush) begin
          case (cnt_q)
            3'd1:    instr_d[31:24] = mem_rdata;
            3'd2:    instr_d[23:16] = mem_rdata;
            3'd3:    instr_d[15:8]  = mem_rdata;
            3'd4:    instr_d[7:0]   = mem_rdata;
            default: ;
          endcase
        end
        if (cnt_q == 3'd4) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
        if (flush) begin
          state_d = S_IDLE;
        end
      end

      S_RESP: begin
        if (rsp_ready || flush) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_instr = instr_q;
  assign rsp_err   = err_q;

endmodule
